// File: rtl/hazard_controller.sv
// Pipeline hazard controller: per-register wait scoreboard, stall/flush/halt
// sequencing for the IF/ID/EX front end, and a saturating stall-cycle counter.
module hazard_controller #(
  parameter int LOAD_WAIT = 1,
  parameter int MUL_WAIT  = 3
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        halt,
  input  logic        id_valid,
  input  logic [2:0]  id_rs1,
  input  logic [2:0]  id_rs2,
  input  logic        id_use_rs1,
  input  logic        id_use_rs2,
  input  logic [2:0]  id_rd,
  input  logic        id_wr_en,
  input  logic        id_is_load,
  input  logic        id_is_mul,
  input  logic        ex_branch_taken,
  output logic        if_stall,
  output logic        id_stall,
  output logic        ex_bubble,
  output logic        flush,
  output logic [1:0]  state,
  output logic [15:0] stall_cycles
);

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_STALL = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;
  localparam logic [1:0] ST_HALT  = 2'd3;

  localparam logic [1:0] LOAD_CNT = 2'(LOAD_WAIT);
  localparam logic [1:0] MUL_CNT  = 2'(MUL_WAIT);

  logic [1:0]  cnt [8];
  logic [1:0]  state_q;
  logic [1:0]  state_d;
  logic [15:0] stall_q;
  logic        hazard;
  logic        flush_c;
  logic        stall_c;
  logic        issue;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign hazard = id_valid & ((id_use_rs1 & (cnt[id_rs1] != 2'd0)) |
                              (id_use_rs2 & (cnt[id_rs2] != 2'd0)));

  // A taken branch squashes immediately in any state; the stall holds only
  // while a hazard is live, so the consumer issues in the cycle it clears.
  always_comb begin
    flush_c = resetn & (ex_branch_taken | (state_q == ST_FLUSH));
    stall_c = resetn & ~flush_c &
              ((state_q == ST_HALT) |
               (((state_q == ST_RUN) | (state_q == ST_STALL)) & hazard));
    issue   = id_valid & ~stall_c & ~flush_c & (state_q != ST_HALT);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN: begin
        if (ex_branch_taken) state_d = ST_FLUSH;
        else if (halt)       state_d = ST_HALT;
        else if (hazard)     state_d = ST_STALL;
        else                 state_d = ST_RUN;
      end
      ST_STALL: begin
        if (ex_branch_taken) state_d = ST_FLUSH;
        else if (hazard)     state_d = ST_STALL;
        else                 state_d = ST_RUN;
      end
      default: begin
        if (ex_branch_taken) state_d = ST_FLUSH;
        else if (halt)       state_d = ST_HALT;
        else                 state_d = ST_RUN;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_RUN;
      stall_q <= 16'd0;
    end else begin
      state_q <= state_d;
      if (stall_c) stall_q <= sat_inc16(stall_q);
    end
  end

  // Issue write wins over the decrement of the same entry.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < 8; i++) cnt[i] <= 2'd0;
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (issue && id_wr_en && (id_rd == 3'(i)))
          cnt[i] <= id_is_load ? LOAD_CNT : (id_is_mul ? MUL_CNT : 2'd0);
        else if (cnt[i] != 2'd0)
          cnt[i] <= cnt[i] - 2'd1;
      end
    end
  end

  assign if_stall     = stall_c;
  assign id_stall     = stall_c;
  assign ex_bubble    = stall_c | flush_c;
  assign flush        = flush_c;
  assign state        = state_q;
  assign stall_cycles = stall_q;

endmodule

// File: tb/tb_hazard_controller.sv
// Bench for hazard_controller: directed scenarios plus randomized traffic,
// each compared against a behavioural model of the scoreboard/stall rules.
module tb_hazard_controller;

  logic        clk = 1'b0;
  logic        resetn, halt, id_valid;
  logic [2:0]  id_rs1, id_rs2, id_rd;
  logic        id_use_rs1, id_use_rs2, id_wr_en, id_is_load, id_is_mul;
  logic        ex_branch_taken;
  logic        if_stall, id_stall, ex_bubble, flush;
  logic [1:0]  state;
  logic [15:0] stall_cycles;
  logic [21:0] dut_vec;

  int n_cmp = 0;
  int n_bad = 0;

  // model state: wait per register, mode 0=RUN 1=STALL 2=FLUSH 3=HALT
  int m_cnt[8];
  int m_state;
  int m_sc;

  hazard_controller #(.LOAD_WAIT(1), .MUL_WAIT(3)) dut (
    .clk(clk), .resetn(resetn), .halt(halt), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .id_rd(id_rd), .id_wr_en(id_wr_en), .id_is_load(id_is_load), .id_is_mul(id_is_mul),
    .ex_branch_taken(ex_branch_taken), .if_stall(if_stall), .id_stall(id_stall),
    .ex_bubble(ex_bubble), .flush(flush), .state(state), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;
  assign dut_vec = {if_stall, id_stall, ex_bubble, flush, state, stall_cycles};

  function automatic bit m_hazard();
    return id_valid && ((id_use_rs1 && m_cnt[id_rs1] > 0) || (id_use_rs2 && m_cnt[id_rs2] > 0));
  endfunction

  function automatic bit m_flush();
    return ex_branch_taken || m_state == 2;
  endfunction

  function automatic bit m_stall();
    if (m_flush()) return 1'b0;
    if (m_state == 3) return 1'b1;
    return m_hazard();
  endfunction

  function automatic logic [21:0] m_vec();
    bit s, f;
    if (!resetn) return 22'h0;
    s = m_stall();
    f = m_flush();
    return {s, s, s | f, f, 2'(m_state), 16'(m_sc)};
  endfunction

  task automatic model_reset();
    for (int r = 0; r < 8; r++) m_cnt[r] = 0;
    m_state = 0;
    m_sc = 0;
  endtask

  task automatic model_tick();
    bit s, f, hz, iss;
    int nxt;
    if (!resetn) begin
      model_reset();
      return;
    end
    s = m_stall();
    f = m_flush();
    hz = m_hazard();
    iss = id_valid && !s && !f && m_state != 3;
    if (ex_branch_taken) nxt = 2;
    else if (m_state == 0) nxt = halt ? 3 : (hz ? 1 : 0);
    else if (m_state == 1) nxt = hz ? 1 : 0;
    else nxt = halt ? 3 : 0;
    for (int r = 0; r < 8; r++) begin
      if (iss && id_wr_en && r == int'(id_rd))
        m_cnt[r] = id_is_load ? 1 : (id_is_mul ? 3 : 0);
      else if (m_cnt[r] > 0)
        m_cnt[r] = m_cnt[r] - 1;
    end
    if (s && m_sc < 65535) m_sc = m_sc + 1;
    m_state = nxt;
  endtask

  task automatic drive(input bit v, input int rs1, input bit u1, input int rs2, input bit u2,
                       input int rd, input bit we, input bit ld, input bit mul,
                       input bit br, input bit hl);
    id_valid = v; id_rs1 = 3'(rs1); id_use_rs1 = u1; id_rs2 = 3'(rs2); id_use_rs2 = u2;
    id_rd = 3'(rd); id_wr_en = we; id_is_load = ld; id_is_mul = mul;
    ex_branch_taken = br; halt = hl;
    #2;
  endtask

  task automatic advance();
    model_tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    drive(1, 1, 1, 2, 1, 3, 1, 1, 0, 1, 1);
    n_cmp++;
    if (dut_vec !== 22'h0) begin
      n_bad++; $display("FAIL reset_outputs got=%h exp=%h", dut_vec, 22'h0);
    end
    @(posedge clk); #1;
    resetn = 1'b1;
    model_reset();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    n_cmp++;
    if (dut_vec !== 22'h0) begin
      n_bad++; $display("FAIL reset_release got=%h exp=%h", dut_vec, 22'h0);
    end
    for (int r = 0; r < 8; r++) begin
      n_cmp++;
      if (dut.cnt[r] !== 2'd0) begin
        n_bad++; $display("FAIL reset_cnt%0d got=%0d exp=0", r, dut.cnt[r]);
      end
    end
    advance();
  endtask

  task automatic test_load_use();
    int stalls = 0;
    bit done;
    do_reset();
    drive(1, 0, 0, 0, 0, 3, 1, 1, 0, 0, 0);
    n_cmp++;
    if (dut_vec !== m_vec()) begin
      n_bad++; $display("FAIL load_issue got=%h exp=%h", dut_vec, m_vec());
    end
    advance();
    for (int c = 0; c < 8; c++) begin
      drive(1, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0);
      n_cmp++;
      if (dut_vec !== m_vec()) begin
        n_bad++; $display("FAIL load_use c=%0d got=%h exp=%h", c, dut_vec, m_vec());
      end
      if (id_stall === 1'b1) stalls++;
      done = !m_stall();
      advance();
      if (done) break;
    end
    n_cmp++;
    if (stalls != 1) begin
      n_bad++; $display("FAIL load_stall_len got=%0d exp=1", stalls);
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    n_cmp++;
    if (stall_cycles !== 16'd1) begin
      n_bad++; $display("FAIL load_stall_cycles got=%0d exp=1", stall_cycles);
    end
    advance();
  endtask

  task automatic test_mul_use();
    int stalls = 0;
    bit done;
    do_reset();
    drive(1, 0, 0, 0, 0, 5, 1, 0, 1, 0, 0);
    advance();
    for (int c = 0; c < 10; c++) begin
      drive(1, 0, 0, 5, 1, 0, 0, 0, 0, 0, 0);
      n_cmp++;
      if (dut_vec !== m_vec()) begin
        n_bad++; $display("FAIL mul_use c=%0d got=%h exp=%h", c, dut_vec, m_vec());
      end
      if (id_stall === 1'b1) stalls++;
      done = !m_stall();
      advance();
      if (done) break;
    end
    n_cmp++;
    if (stalls != 3) begin
      n_bad++; $display("FAIL mul_stall_len got=%0d exp=3", stalls);
    end
    drive(1, 0, 0, 0, 0, 5, 1, 0, 1, 0, 0);
    advance();
    drive(1, 0, 0, 5, 0, 0, 0, 0, 0, 0, 0);
    n_cmp++;
    if (id_stall !== 1'b0 || dut_vec !== m_vec()) begin
      n_bad++; $display("FAIL mul_unused_rs2 got=%h exp=%h", dut_vec, m_vec());
    end
    advance();
  endtask

  task automatic test_alu_forward();
    do_reset();
    drive(1, 0, 0, 0, 0, 2, 1, 0, 0, 0, 0);
    advance();
    n_cmp++;
    if (dut.cnt[2] !== 2'd0) begin
      n_bad++; $display("FAIL alu_cnt2 got=%0d exp=0", dut.cnt[2]);
    end
    drive(1, 2, 1, 2, 1, 0, 0, 0, 0, 0, 0);
    n_cmp++;
    if (id_stall !== 1'b0 || dut_vec !== m_vec()) begin
      n_bad++; $display("FAIL alu_read got=%h exp=%h", dut_vec, m_vec());
    end
    advance();
  endtask

  task automatic test_branch_flush();
    do_reset();
    drive(1, 0, 0, 0, 0, 4, 1, 0, 1, 0, 0);
    advance();
    drive(1, 4, 1, 0, 0, 6, 1, 1, 0, 0, 0);
    n_cmp++;
    if (dut_vec !== m_vec() || id_stall !== 1'b1) begin
      n_bad++; $display("FAIL br_prestall got=%h exp=%h", dut_vec, m_vec());
    end
    advance();
    drive(1, 4, 1, 0, 0, 6, 1, 1, 0, 1, 0);
    n_cmp++;
    if (flush !== 1'b1 || state !== 2'd1 || dut_vec !== m_vec()) begin
      n_bad++; $display("FAIL br_in_stall got=%h exp=%h", dut_vec, m_vec());
    end
    advance();
    drive(1, 4, 1, 0, 0, 6, 1, 1, 0, 0, 0);
    n_cmp++;
    if (state !== 2'd2 || dut_vec !== m_vec()) begin
      n_bad++; $display("FAIL br_flush_state got=%h exp=%h", dut_vec, m_vec());
    end
    advance();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    n_cmp++;
    if (state !== 2'd0 || dut_vec !== m_vec()) begin
      n_bad++; $display("FAIL br_back_run got=%h exp=%h", dut_vec, m_vec());
    end
    n_cmp++;
    if (dut.cnt[6] !== 2'd0) begin
      n_bad++; $display("FAIL br_squashed_cnt6 got=%0d exp=0", dut.cnt[6]);
    end
    advance();
  endtask

  task automatic test_halt();
    do_reset();
    drive(1, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0);
    advance();
    for (int c = 0; c < 4; c++) begin
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      n_cmp++;
      if (dut_vec !== m_vec()) begin
        n_bad++; $display("FAIL halt_hold c=%0d got=%h exp=%h", c, dut_vec, m_vec());
      end
      advance();
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    n_cmp++;
    if (state !== 2'd3 || dut_vec !== m_vec()) begin
      n_bad++; $display("FAIL halt_release got=%h exp=%h", dut_vec, m_vec());
    end
    advance();
    drive(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    n_cmp++;
    if (state !== 2'd0 || id_stall !== 1'b0 || stall_cycles !== 16'd4) begin
      n_bad++; $display("FAIL halt_exit got=%h exp=%h", dut_vec, 22'h000004);
    end
    n_cmp++;
    if (dut.cnt[1] !== 2'd0) begin
      n_bad++; $display("FAIL halt_cnt1 got=%0d exp=0", dut.cnt[1]);
    end
    advance();
  endtask

  task automatic test_random();
    bit hl = 0;
    int k;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 11) == 0) hl = !hl;
      k = int'($urandom_range(0, 3));
      drive($urandom_range(0, 3) != 0, int'($urandom_range(0, 7)), 1'($urandom),
            int'($urandom_range(0, 7)), 1'($urandom), int'($urandom_range(0, 7)),
            $urandom_range(0, 3) != 0, k == 0, k == 1, $urandom_range(0, 9) == 0, hl);
      n_cmp++;
      if (dut_vec !== m_vec()) begin
        n_bad++; $display("FAIL rand_out c=%0d got=%h exp=%h", c, dut_vec, m_vec());
      end
      for (int r = 0; r < 8; r++) begin
        n_cmp++;
        if (dut.cnt[r] !== 2'(m_cnt[r])) begin
          n_bad++; $display("FAIL rand_cnt%0d c=%0d got=%0d exp=%0d", r, c, dut.cnt[r], m_cnt[r]);
        end
      end
      advance();
    end
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    drive(1, 0, 0, 0, 0, 5, 1, 0, 1, 0, 0);
    advance();
    drive(1, 0, 0, 5, 1, 0, 0, 0, 0, 0, 0);
    advance();
    drive(1, 0, 0, 5, 1, 0, 0, 0, 0, 0, 0);
    n_cmp++;
    if (id_stall !== 1'b1 || state !== 2'd1) begin
      n_bad++; $display("FAIL mid_prestall got=%h exp=%h", dut_vec, m_vec());
    end
    resetn = 1'b0;
    #1;
    n_cmp++;
    if (dut_vec !== 22'h0) begin
      n_bad++; $display("FAIL mid_reset_out got=%h exp=%h", dut_vec, 22'h0);
    end
    for (int r = 0; r < 8; r++) begin
      n_cmp++;
      if (dut.cnt[r] !== 2'd0) begin
        n_bad++; $display("FAIL mid_reset_cnt%0d got=%0d exp=0", r, dut.cnt[r]);
      end
    end
    model_reset();
    @(posedge clk); #1;
    resetn = 1'b1;
  endtask

  task automatic test_saturation();
    do_reset();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    for (int c = 0; c < 65540; c++) advance();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    n_cmp++;
    if (stall_cycles !== 16'hFFFF || dut_vec !== m_vec()) begin
      n_bad++; $display("FAIL stall_sat got=%h exp=%h", dut_vec, m_vec());
    end
    advance();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    n_cmp++;
    if (stall_cycles !== 16'hFFFF) begin
      n_bad++; $display("FAIL stall_sat_hold got=%h exp=ffff", stall_cycles);
    end
    advance();
  endtask

  initial begin
    model_reset();
    test_reset();
    test_load_use();
    test_mul_use();
    test_alu_forward();
    test_branch_flush();
    test_halt();
    test_random();
    test_reset_mid_stall();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
